// File: rtl/omr_pkg.sv
// Shared constants and enums for the OMR sheet reader.
// Optional build macro used by this slice: OMR_MULTIMARK_CLEAR_EN.
package omr_pkg;

  localparam int NUM_Q = 10;
  localparam int OPT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } row_class_e;

endpackage

// File: rtl/omr_row_classify.sv
// Combinational row classifier: blank / single / multi-mark plus the nibble to store.
// With OMR_MULTIMARK_CLEAR_EN defined, multi-mark rows are stored as all zeros.
module omr_row_classify #(
  parameter int OPT_W = omr_pkg::OPT_W
) (
  input  logic [OPT_W-1:0]   row_bits,
  output omr_pkg::row_class_e row_class,
  output logic [OPT_W-1:0]   stored_bits
);
  import omr_pkg::*;

  localparam int CNT_W = $clog2(OPT_W + 1);

  logic [CNT_W-1:0] ones;

  always_comb begin
    ones = '0;
    for (int i = 0; i < OPT_W; i++) begin
      ones = ones + CNT_W'(row_bits[i]);
    end
  end

  always_comb begin
    if (ones == '0) begin
      row_class = BLANK;
    end else if (ones == CNT_W'(1)) begin
      row_class = SINGLE;
    end else begin
      row_class = MULTI;
    end
  end

`ifdef OMR_MULTIMARK_CLEAR_EN
  assign stored_bits = (row_class == MULTI) ? '0 : row_bits;
`else
  assign stored_bits = row_bits;
`endif

endmodule

// File: rtl/omr_sheet_reader.sv
// OMR front end: collects NUM_Q scanned rows into a packed answer word and holds it for the grader.
// Multi-mark storage behaviour follows OMR_MULTIMARK_CLEAR_EN (see omr_row_classify).
module omr_sheet_reader #(
  parameter int NUM_Q = omr_pkg::NUM_Q,
  parameter int OPT_W = omr_pkg::OPT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sheet_start,
  input  logic                   row_valid,
  input  logic [OPT_W-1:0]       row_bits,
  output logic                   row_ready,
  output logic [NUM_Q*OPT_W-1:0] student_answers,
  output logic                   sheet_valid,
  input  logic                   sheet_ack,
  output logic [3:0]             blank_cnt,
  output logic [3:0]             multi_cnt,
  output logic                   busy
);
  import omr_pkg::*;

  localparam int                IDX_W    = $clog2(NUM_Q);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_Q - 1);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [NUM_Q*OPT_W-1:0]   ans_q, ans_d;
  logic [3:0]               blank_q, blank_d;
  logic [3:0]               multi_q, multi_d;

  row_class_e               row_class;
  logic [OPT_W-1:0]         stored_bits;
  logic                     row_fire;

  omr_row_classify #(.OPT_W(OPT_W)) u_classify (
    .row_bits    (row_bits),
    .row_class   (row_class),
    .stored_bits (stored_bits)
  );

  // Row handshake: a row transfers on a cycle where row_valid && row_ready.
  // row_ready is a function of state and sheet_start only, never of row_valid;
  // the scanner keeps row_bits stable while waiting.
  assign row_ready = (state_q == COLLECT) && !sheet_start;
  assign row_fire  = row_valid && row_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ans_d   = ans_q;
    blank_d = blank_q;
    multi_d = multi_q;
    unique case (state_q)
      IDLE: begin
        if (sheet_start) begin
          state_d = COLLECT;
          idx_d   = '0;
          ans_d   = '0;
          blank_d = '0;
          multi_d = '0;
        end
      end
      COLLECT: begin
        if (sheet_start) begin
          idx_d   = '0;
          ans_d   = '0;
          blank_d = '0;
          multi_d = '0;
        end else if (row_fire) begin
          // First row lands in the most significant nibble.
          for (int q = 0; q < NUM_Q; q++) begin
            if (q == NUM_Q - 1 - int'(idx_q)) begin
              ans_d[q*OPT_W +: OPT_W] = stored_bits;
            end
          end
          if (row_class == BLANK && blank_q != 4'hF) begin
            blank_d = blank_q + 4'd1;
          end
          if (row_class == MULTI && multi_q != 4'hF) begin
            multi_d = multi_q + 4'd1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = HOLD;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (sheet_ack) begin
          if (sheet_start) begin
            state_d = COLLECT;
            idx_d   = '0;
            ans_d   = '0;
            blank_d = '0;
            multi_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ans_q   <= '0;
      blank_q <= '0;
      multi_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ans_q   <= ans_d;
      blank_q <= blank_d;
      multi_q <= multi_d;
    end
  end

  assign student_answers = ans_q;
  assign blank_cnt       = blank_q;
  assign multi_cnt       = multi_q;
  assign sheet_valid     = (state_q == HOLD);
  assign busy            = (state_q != IDLE);

endmodule

// File: doc/omr_sheet_reader.md
# omr_sheet_reader

Sequential front end of the OMR grading path. It accepts one answer row per question from the scanner over a valid/ready handshake and classifies each row as blank, single-mark or multi-mark. It assembles the rows into the packed 40-bit `student_answers` word that the grader consumes, then holds that word with `sheet_valid` until the grader acknowledges it. This block is the writer of the grader's `student_answers` input.

## Interface
Parameters:
- `NUM_Q`, 10, questions per sheet.
- `OPT_W`, 4, options per question (one bit per bubble).

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `sheet_start`  in  1  begin (or restart) collection of a sheet.
- `row_valid`  in  1  scanner presents a row.
- `row_bits`  in  OPT_W  bubble marks for the current question; bit set means marked.
- `row_ready`  out  1  block accepts the row this cycle.
- `student_answers`  out  NUM_Q*OPT_W  packed sheet; the first row received lands in the MSB nibble.
- `sheet_valid`  out  1  `student_answers` is complete and stable.
- `sheet_ack`  in  1  grader has consumed the sheet.
- `blank_cnt`  out  4  number of all-zero rows in the sheet.
- `multi_cnt`  out  4  number of rows with more than one bit set.
- `busy`  out  1  high in COLLECT or HOLD.

## Operation
- FSM states: IDLE, COLLECT, HOLD.
- IDLE:
  - `row_ready` = 0.
  - On `sheet_start` the block clears the answer vector, the row index and both counters, then moves to COLLECT.
- COLLECT:
  - `row_ready` = !`sheet_start` (combinational).
  - A handshake (`row_valid` && `row_ready`) stores the classified row at nibble index `NUM_Q-1-idx` and increments `idx`.
  - A blank row increments `blank_cnt`. A multi-mark row increments `multi_cnt`.
  - The handshake with `idx == NUM_Q-1` moves the block to HOLD.
- HOLD:
  - `sheet_valid` = 1; `student_answers` and both counters are frozen.
  - `sheet_ack` moves the block to IDLE, or directly to COLLECT (with a clear) if `sheet_start` is high in the same cycle.
- `sheet_start` in COLLECT aborts the sheet and restarts it: the block clears the vector and counters and sets `idx` to 0. A row offered in that cycle is not accepted.
- `sheet_start` in HOLD without `sheet_ack` is ignored.
- The index counter is `$clog2(NUM_Q)` wide and never wraps past `NUM_Q-1`.
- The counters are saturating 4-bit values; with `NUM_Q` = 10 they cannot overflow.

## Timing
- Reset values:
  - FSM state is IDLE.
  - `student_answers` = 0 and `idx` = 0.
  - `row_ready`, `sheet_valid` and `busy` are 0.
  - `blank_cnt` and `multi_cnt` are 0.
- Reset takes effect asynchronously. Reset in the middle of a sheet discards it completely.
- Latency: `sheet_valid` rises on the clock edge after the NUM_Q-th handshake.
  - Minimum sheet time is 1 cycle for start plus NUM_Q cycles for rows, with `sheet_valid` visible in the next cycle.
- `sheet_valid` falls on the clock edge after `sheet_ack` is sampled high.
- `row_ready` never depends on `row_valid`.
- The scanner must hold `row_bits` stable while `row_valid` is high and `row_ready` is low.

## Configuration
- Macro: `OMR_MULTIMARK_CLEAR_EN`.
- Defined: a multi-mark row is stored as all zeros, so the grader treats it as unanswered. `multi_cnt` still counts it.
- Undefined: a multi-mark row is stored exactly as received.
- Blank and single-mark rows are stored as received in both builds.

## Structure
- Package `omr_pkg` holds:
  - constants `NUM_Q` and `OPT_W` as defaults;
  - the FSM state enum (IDLE, COLLECT, HOLD);
  - the row class enum (BLANK, SINGLE, MULTI).
- Sub-module `omr_row_classify`: combinational. It takes `row_bits` and produces the class and the stored nibble, honouring `OMR_MULTIMARK_CLEAR_EN`.
- The top level contains the FSM, the index counter, the vector register and the counters.

## Test plan
- **Full sheet:** start, then rows 0001, 0010, 0010, 0100, 0100, 0100, 0001, 1000, 1000, 1000 with `row_valid` held high.
  - `student_answers` = 40'h1224441888 and `sheet_valid` rises the cycle after the 10th row.
  - `blank_cnt` = 0 and `multi_cnt` = 0.
- **Blank and multi-mark rows:** row 4 = 0101 and row 9 = 0000, other rows as in the full-sheet case.
  - Macro defined: nibble 5 (bits [23:20]) = 0 and nibble 0 = 0.
  - Macro undefined: nibble 5 = 0101.
  - Both builds: `multi_cnt` = 1 and `blank_cnt` = 1.
- **Backpressure in HOLD:** keep `row_valid` high in HOLD.
  - `row_ready` stays 0 and the output is unchanged.
  - `sheet_ack` makes the block return to IDLE next cycle, with `sheet_valid` = 0.
- **Abort:** send 3 rows, then `sheet_start` together with `row_valid`.
  - The row is not accepted and `idx` is 0.
  - 10 further rows produce a correct sheet containing only the new rows.
- **Ack and start together:** in HOLD, assert `sheet_ack` and `sheet_start` in the same cycle.
  - Next cycle: COLLECT, `sheet_valid` = 0, vector cleared.
- **Reset mid-sheet:** assert `reset` low after 5 rows.
  - All outputs return to 0 immediately (asynchronously).
  - After reset is released the block waits in IDLE for `sheet_start`.
